// File: rtl/bit_sd_mod_if.sv
// Sample handshake bundle for the sigma-delta modulator: the producer drives
// inValid/dataIn and the modulator returns inReady.
interface bit_sd_mod_if #(
  parameter int IN_WIDTH = 16
);
  logic                inValid;
  logic                inReady;
  logic [IN_WIDTH-1:0] dataIn;

  modport master (output inValid, output dataIn, input inReady);
  modport slave  (input inValid, input dataIn, output inReady);
endinterface

// File: rtl/bit_sd_mod.sv
// First-order sigma-delta modulator: multi-bit sample in, 1-bit density out, one registered step per en.
// One-deep pending buffer; inReady drops while it is full and rises the cycle after a boundary empties it.
module bit_sd_mod #(
  parameter int IN_WIDTH = 16,
  parameter int OSR_BITS = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  bit_sd_mod_if.slave   in_if,
  output logic          dataOut,
  output logic          underrun
);

  logic [IN_WIDTH-1:0] pending;
  logic                pendValid;
  logic [IN_WIDTH-1:0] active;
  logic [IN_WIDTH-1:0] acc;
  logic [OSR_BITS-1:0] cnt;
  logic [IN_WIDTH:0]   sum;
  logic                boundary;
  logic                xfer;

  assign in_if.inReady = !pendValid;
  assign xfer          = in_if.inValid && !pendValid;
  assign boundary      = en && (cnt == '1);
  assign sum           = {1'b0, acc} + {1'b0, active};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      pendValid <= 1'b0;
      active    <= '0;
      acc       <= '0;
      cnt       <= '0;
      dataOut   <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      // A transfer never coincides with a consuming boundary: inReady was low.
      if (xfer) begin
        pending   <= in_if.dataIn;
        pendValid <= 1'b1;
      end else if (boundary && pendValid) begin
        pendValid <= 1'b0;
      end

      if (boundary && pendValid) begin
        active <= pending;
      end

      underrun <= boundary && !pendValid;

      // The accumulator carries across boundaries, so quantisation error is never reset.
      if (en) begin
        acc     <= sum[IN_WIDTH-1:0];
        dataOut <= sum[IN_WIDTH];
        cnt     <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bit_sd_mod.sv
// Bench for bit_sd_mod at IN_WIDTH=8, OSR_BITS=3 against an unbounded-sum density model.
module tb_bit_sd_mod;

  localparam int W   = 8;
  localparam int OSR = 3;
  localparam int PER = 1 << OSR;

  logic clk;
  logic rst_n;
  logic en;
  logic dataOut;
  logic underrun;

  bit_sd_mod_if #(.IN_WIDTH(W)) bus ();

  bit_sd_mod #(.IN_WIDTH(W), .OSR_BITS(OSR)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in_if    (bus),
    .dataOut  (dataOut),
    .underrun (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Reference: buffered samples in a queue, output bit = increment of floor(total/2^W)
  // where total is the plain running sum of every active value stepped so far.
  logic [W-1:0] m_q[$];
  logic [W-1:0] m_active;
  longint       m_total;
  int           m_steps;
  logic         m_out;
  logic         m_und;
  logic         m_xfer;
  int           ones;

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %b want %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_active = '0;
    m_total  = 0;
    m_steps  = 0;
    m_out    = 1'b0;
    m_und    = 1'b0;
  endtask

  // Called at posedge+1: drive, check inReady, take the edge, check outputs at posedge+1.
  task automatic step(input logic e, input logic v, input logic [W-1:0] d);
    longint old;
    logic   rdy;
    en          = e;
    bus.inValid = v;
    bus.dataIn  = d;
    rdy = (m_q.size() == 0);
    chk("inReady", bus.inReady, rdy);
    m_xfer = v && rdy;
    m_und  = 1'b0;
    if (e) begin
      m_steps++;
      old     = m_total;
      m_total = m_total + longint'(m_active);
      m_out   = ((m_total >> W) - (old >> W)) != 0;
      if (m_steps % PER == 0) begin
        if (m_q.size() != 0) m_active = m_q.pop_front();
        else                 m_und = 1'b1;
      end
    end
    if (m_xfer) m_q.push_back(d);
    @(posedge clk);
    #1;
    chk("dataOut", dataOut, m_out);
    chk("underrun", underrun, m_und);
    if (dataOut === 1'b1) ones++;
  endtask

  task automatic async_reset();
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_dataOut", dataOut, 1'b0);
    chk("rst_inReady", bus.inReady, 1'b1);
    chk("rst_underrun", underrun, 1'b0);
    model_reset();
    en          = 1'b0;
    bus.inValid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    ones        = 0;
    rst_n       = 1'b0;
    en          = 1'b0;
    bus.inValid = 1'b0;
    bus.dataIn  = '0;
    model_reset();
    #12;
    chk("reset_dataOut", dataOut, 1'b0);
    chk("reset_inReady", bus.inReady, 1'b1);
    chk("reset_underrun", underrun, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Half scale: zeros for one period, then 0,1,0,1 with underruns at later boundaries.
    step(1'b1, 1'b1, 8'd128);
    for (int i = 1; i < PER; i++) step(1'b1, 1'b0, 8'd0);
    ones = 0;
    for (int i = 0; i < PER; i++) step(1'b1, 1'b0, 8'd0);
    vectors++;
    assert (ones == PER / 2) else begin
      miscompares++;
      $error("FAIL half_ones: got %0d want %0d", ones, PER / 2);
    end
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'd0);

    // Reset mid-stream while active = 128.
    async_reset();

    // Quarter scale: 2 ones per period.
    step(1'b1, 1'b1, 8'd64);
    for (int i = 1; i < PER; i++) step(1'b1, 1'b0, 8'd0);
    ones = 0;
    for (int i = 0; i < PER; i++) step(1'b1, 1'b0, 8'd0);
    vectors++;
    assert (ones == 2) else begin
      miscompares++;
      $error("FAIL quarter_ones: got %0d want 2", ones);
    end
    for (int i = 0; i < PER; i++) step(1'b1, 1'b0, 8'd0);

    // Back-pressure: A accepted at once, B stalls until after the next boundary.
    step(1'b1, 1'b1, 8'd32);
    m_xfer = 1'b0;
    for (int i = 0; i < 4 * PER && !m_xfer; i++) step(1'b1, 1'b1, 8'd224);
    for (int i = 0; i < 3 * PER; i++) step(1'b1, 1'b0, 8'd0);

    // Enable gating: en one cycle in four, value 128.
    async_reset();
    for (int i = 0; i < 4 * 3 * PER; i++) step((i % 4) == 0, i == 0, 8'd128);

    // Transfer on the boundary edge itself: underrun still pulses, value lands a period later.
    for (int i = 0; i < 4 * PER && (m_steps % PER) != PER - 1; i++) step(1'b1, 1'b0, 8'd0);
    step(1'b1, 1'b1, 8'd64);
    for (int i = 0; i < 3 * PER; i++) step(1'b1, 1'b0, 8'd0);

    // Randomised traffic with random enable strobing.
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, W'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bit_sd_mod.md
# bit_sd_mod

First-order sigma-delta modulator that converts an unsigned multi-bit sample stream into a 1-bit pulse-density stream whose ones-density equals `dataIn / 2^IN_WIDTH`. It is the transmit-side counterpart of the team's 1-bit low-pass filters: a modulator output fed through a 1-bit filter recovers the sample value. Samples arrive over a valid/ready handshake, one per output period of `2^OSR_BITS` enabled cycles. The modulator can be slowed by strobing `en`.

## Interface
- `IN_WIDTH`, 16: sample width in bits; also the accumulator width.
- `OSR_BITS`, 6: the output period is `2^OSR_BITS` enabled cycles per input sample.

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset. Asynchronous and active-low.
- `en`  in  1  modulator step strobe. The accumulator and period counter advance only when it is high.
- `inValid`  in  1  `dataIn` holds a sample.
- `inReady`  out  1  the pending buffer is empty and can accept a sample.
- `dataIn`  in  IN_WIDTH  unsigned sample.
- `dataOut`  out  1  modulated bitstream. Registered.
- `underrun`  out  1  one-cycle pulse when a period boundary finds no pending sample.

## Operation
- **Registers:**
  - `pending` (IN_WIDTH) plus `pendValid`.
  - `active` (IN_WIDTH): the sample currently being modulated.
  - `acc` (IN_WIDTH).
  - `cnt` (OSR_BITS).
  - `dataOut`, `underrun`.
- **Async reset:** all registers clear to 0, except that `inReady` reads 1. Reset asserted mid-operation discards the pending and active samples immediately.
- **Handshake:**
  - `inReady = !pendValid`, driven combinationally from the register.
  - A transfer occurs on a rising edge where `inValid && inReady`. At that edge `pending <= dataIn` and `pendValid <= 1`.
  - `dataIn` is ignored when no transfer occurs.
- **Modulation:** on an edge with `en = 1`:
  - `{carry, sum} = acc + active`, computed IN_WIDTH+1 bits wide.
  - `acc <= sum`, which wraps modulo `2^IN_WIDTH`.
  - `dataOut <= carry`.
- **Period counter:** `cnt` increments modulo `2^OSR_BITS` on each `en` edge. A boundary is an `en` edge with `cnt == 2^OSR_BITS-1`.
- **At a boundary:**
  - If `pendValid` is 1 before the edge: `active <= pending` and `pendValid <= 0`. The step at this edge still uses the old `active`.
  - Otherwise `active` holds its value and `underrun <= 1` for exactly one cycle.
  - The accumulator is never cleared at a boundary, so no phase reset occurs and the error is carried across samples.
- **Same-edge transfer and boundary:** if a transfer happens on the same edge as a boundary while `pendValid` was 0, the new sample lands in `pending` and `underrun` still pulses. The sample is used at the next boundary.
- **Same-edge clear and refill:** a transfer cannot coincide with a boundary that clears `pendValid`, because `inReady` was 0 on that edge.
- **`en = 0`:** `acc`, `cnt`, `active`, and `dataOut` all hold. The handshake still operates.
- **Density range:** `active = 0` gives all zeros. `active = 2^IN_WIDTH-1` gives one zero every `2^IN_WIDTH` steps. A full-scale all-ones output is unreachable by design.
- `underrun` is 0 on every cycle without a boundary.

## Timing
- `dataOut` changes only on `en` edges. It reflects the carry of the step taken on that edge, so the register latency is 1 cycle.
- **Sample latency:** a sample accepted before boundary k affects `dataOut` from the first `en` edge after boundary k.
- **First sample after reset:** `cnt = 0`, so the first boundary comes at the `2^OSR_BITS`-th `en` edge. The output is all zeros until then.
- **Throughput:** one sample per period. `inReady` rises the cycle after the boundary edge that consumed `pending`.

## Test plan
- **Reset:** hold `rst_n = 0`, then release.
  - Required: `dataOut = 0`, `inReady = 1`, `underrun = 0`.
  - Assert `rst_n` asynchronously mid-stream with `active = 128`: all outputs return to their reset values within the same cycle, with no clock edge.
- **Half-scale pattern:** `IN_WIDTH = 8`, `OSR_BITS = 3`, `en = 1`. Send 128 at t = 0.
  - Required: `dataOut = 0` for 8 edges, then alternating 0,1,0,1….
  - Required: `underrun` pulses at each later boundary.
- **Quarter-scale pattern:** same configuration, send 64.
  - Required: repeating 0,0,0,1.
  - Required: exactly 2 ones per 8-step period.
- **Back-pressure:** present samples A = 32 and B = 224 back-to-back with `inValid` held high.
  - Required: A is accepted at once; B stalls with `inReady = 0` until the cycle after the next boundary.
  - Required: each sample gives its density over one period, with no underrun while fed continuously.
- **Enable gating:** same configuration, `en` high one cycle in four, value 128.
  - Required: the identical output sequence, stretched 4×.
  - Required: `cnt` and `dataOut` frozen while `en = 0`.
- **Underrun at boundary with same-edge transfer:** raise `inValid` on the boundary edge itself.
  - Required: `underrun` pulses and the old value holds for one more period.
  - Required: the new value takes effect after the following boundary.
